// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the PC sequencer slice:
//   PC_W       - program counter width (16)
//   ccc_e      - branch condition code encodings
//   state_e    - sequencer state encoding (RUN=0, HALTED=1)
//   cond_met() - evaluates a condition code against the {N,V,Z} flags
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int PC_W = 16;

    typedef enum logic [2:0] {
        CC_ZC    = 3'b000,  // Z=0
        CC_ZS    = 3'b001,  // Z=1
        CC_GT    = 3'b010,  // Z=0 and N=0
        CC_NS    = 3'b011,  // N=1
        CC_GE    = 3'b100,  // Z=1 or (Z=0 and N=0)
        CC_LE    = 3'b101,  // N=1 or Z=1
        CC_VS    = 3'b110,  // V=1
        CC_ALWAY = 3'b111   // unconditional
    } ccc_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // flags is packed {N,V,Z}.
    function automatic logic cond_met(input ccc_e cc, input logic [2:0] flags);
        logic n, v, z;
        n = flags[2];
        v = flags[1];
        z = flags[0];
        case (cc)
            CC_ZC:    cond_met = !z;
            CC_ZS:    cond_met = z;
            CC_GT:    cond_met = !z && !n;
            CC_NS:    cond_met = n;
            CC_GE:    cond_met = z || (!z && !n);
            CC_LE:    cond_met = n || z;
            CC_VS:    cond_met = v;
            CC_ALWAY: cond_met = 1'b1;
            default:  cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Control/status bundle between the instruction decode stage (master) and the
// PC sequencer (slave).
//   master drives : stall, hlt, br_en, br_reg, ccc, imm9, reg_tgt, flags
//   slave drives  : pc, pc_plus2, taken, halted (+ br_cnt)
// Optional macro PC_BR_CNT_EN adds the 16-bit taken-branch counter br_cnt.
// -----------------------------------------------------------------------------
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic            stall;
    logic            hlt;
    logic            br_en;
    logic            br_reg;
    logic [2:0]      ccc;
    logic [8:0]      imm9;
    logic [PC_W-1:0] reg_tgt;
    logic [2:0]      flags;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus2;
    logic            taken;
    logic            halted;
`ifdef PC_BR_CNT_EN
    logic [15:0]     br_cnt;
`endif

    modport master (
        output stall, hlt, br_en, br_reg, ccc, imm9, reg_tgt, flags,
`ifdef PC_BR_CNT_EN
        input  br_cnt,
`endif
        input  pc, pc_plus2, taken, halted
    );

    modport slave (
        input  stall, hlt, br_en, br_reg, ccc, imm9, reg_tgt, flags,
`ifdef PC_BR_CNT_EN
        output br_cnt,
`endif
        output pc, pc_plus2, taken, halted
    );

endinterface

// File: rtl/pc_adder_16.sv
// -----------------------------------------------------------------------------
// pc_adder_16
// Plain 16-bit adder, carry-in tied to 0, carry-out discarded (modulo 2^16).
//   a, b : operands
//   sum  : a + b truncated to 16 bits
// -----------------------------------------------------------------------------
module pc_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program counter sequencer with sequential advance, PC-relative (B) and
// register-indirect (BR) conditional branches, stall and HLT.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_sequencer_if.slave (controls in; pc, pc_plus2, taken, halted out)
// Parameter RESET_PC : value loaded into pc on reset.
// Optional macro PC_BR_CNT_EN : adds bus.br_cnt, a saturating count of taken
// branches.
// Edge priority: rst > HALTED hold > stall > hlt > taken branch > sequential.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    pc_sequencer_if.slave    bus
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] b_target;
    logic [PC_W-1:0] b_offset;
    logic            is_branch;
    logic            cond_ok;

    // imm9 is a signed word offset: sign-extend and convert to bytes.
    assign b_offset = {{6{bus.imm9[8]}}, bus.imm9, 1'b0};

    pc_adder_16 u_inc (
        .a   (pc_q),
        .b   (16'h0002),
        .sum (pc_plus2)
    );

    pc_adder_16 u_tgt (
        .a   (pc_plus2),
        .b   (b_offset),
        .sum (b_target)
    );

    assign is_branch = bus.br_en || bus.br_reg;
    assign cond_ok   = cond_met(ccc_e'(bus.ccc), bus.flags);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        if (state_q == ST_HALTED) begin
            // Only reset leaves HALTED; all other inputs are ignored.
            state_d = ST_HALTED;
        end else if (bus.stall) begin
            state_d = ST_RUN;
        end else if (bus.hlt) begin
            state_d = ST_HALTED;
        end else if (is_branch && cond_ok) begin
            // br_reg wins when both branch flavours are asserted.
            pc_d    = bus.br_reg ? bus.reg_tgt : b_target;
            taken_d = 1'b1;
        end else begin
            pc_d = pc_plus2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

`ifdef PC_BR_CNT_EN
    logic [15:0] br_cnt_q;

    // Counts on the same edge taken is set; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= 16'h0000;
        end else if (taken_d && (br_cnt_q != 16'hFFFF)) begin
            br_cnt_q <= br_cnt_q + 16'h0001;
        end
    end

    assign bus.br_cnt = br_cnt_q;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus2 = pc_plus2;
    assign bus.taken    = taken_q;
    assign bus.halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed self-checking bench for pc_sequencer with RESET_PC = 16'h0000.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// The br_cnt scenario is compiled only when PC_BR_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall   = 1'b0;
        bus.hlt     = 1'b0;
        bus.br_en   = 1'b0;
        bus.br_reg  = 1'b0;
        bus.ccc     = 3'b000;
        bus.imm9    = 9'h000;
        bus.reg_tgt = 16'h0000;
        bus.flags   = 3'b000;
    endtask

    // Unconditional BR to tgt; leaves pc == tgt, taken == 1.
    task automatic jump_to(input logic [15:0] tgt);
        idle_inputs();
        bus.br_reg  = 1'b1;
        bus.ccc     = 3'b111;
        bus.reg_tgt = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [15:0] exp_seq [4];
        exp_seq = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.taken !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h taken=%b halted=%b, expected pc=0000 taken=0 halted=0",
                     bus.pc, bus.taken, bus.halted);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.pc !== exp_seq[i] || bus.taken !== 1'b0 || bus.pc_plus2 !== exp_seq[i] + 16'h0002) begin
                n_fail++;
                $display("FAIL seq_%0d: pc=%h pc_plus2=%h taken=%b, expected pc=%h pc_plus2=%h taken=0",
                         i, bus.pc, bus.pc_plus2, bus.taken, exp_seq[i], exp_seq[i] + 16'h0002);
            end
            tick();
        end
    endtask

    task automatic test_b_branch();
        // Taken: pc 0010, Z=1, imm9=-2 -> 0012 - 4 = 000E.
        jump_to(16'h0010);
        bus.br_en = 1'b1;
        bus.ccc   = 3'b001;
        bus.flags = 3'b001;
        bus.imm9  = 9'h1FE;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h000E || bus.taken !== 1'b1) begin
            n_fail++;
            $display("FAIL b_taken: pc=%h taken=%b, expected pc=000e taken=1", bus.pc, bus.taken);
        end
        tick();
        n_tests++;
        if (bus.pc !== 16'h0010 || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL b_taken_pulse: pc=%h taken=%b, expected pc=0010 taken=0", bus.pc, bus.taken);
        end
        // Not taken with Z=0 -> sequential.
        jump_to(16'h0010);
        bus.br_en = 1'b1;
        bus.ccc   = 3'b001;
        bus.flags = 3'b000;
        bus.imm9  = 9'h1FE;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h0012 || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL b_not_taken: pc=%h taken=%b, expected pc=0012 taken=0", bus.pc, bus.taken);
        end
        // Positive offset: pc 0100, imm9=+3 -> 0102 + 6 = 0108.
        jump_to(16'h0100);
        bus.br_en = 1'b1;
        bus.ccc   = 3'b111;
        bus.imm9  = 9'h003;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h0108) begin
            n_fail++;
            $display("FAIL b_forward: pc=%h, expected 0108", bus.pc);
        end
    endtask

    task automatic test_cond_codes();
        // {ccc, flags{N,V,Z}, expected taken}
        logic [6:0] vec [18];
        logic [15:0] start;
        vec = '{
            {3'b000, 3'b000, 1'b1}, {3'b000, 3'b001, 1'b0},
            {3'b001, 3'b001, 1'b1}, {3'b001, 3'b000, 1'b0},
            {3'b010, 3'b000, 1'b1}, {3'b010, 3'b100, 1'b0},
            {3'b010, 3'b001, 1'b0}, {3'b011, 3'b100, 1'b1},
            {3'b011, 3'b000, 1'b0}, {3'b100, 3'b001, 1'b1},
            {3'b100, 3'b000, 1'b1}, {3'b100, 3'b100, 1'b0},
            {3'b101, 3'b100, 1'b1}, {3'b101, 3'b001, 1'b1},
            {3'b101, 3'b000, 1'b0}, {3'b110, 3'b010, 1'b1},
            {3'b110, 3'b101, 1'b0}, {3'b111, 3'b000, 1'b1}
        };
        start = 16'h0200;
        for (int i = 0; i < 18; i++) begin
            logic [6:0]  v;
            logic [15:0] exp_pc;
            v = vec[i];
            jump_to(start);
            bus.br_reg  = 1'b1;
            bus.ccc     = v[6:4];
            bus.flags   = v[3:1];
            bus.reg_tgt = 16'h0800;
            tick();
            idle_inputs();
            exp_pc = v[0] ? 16'h0800 : 16'h0202;
            n_tests++;
            if (bus.pc !== exp_pc || bus.taken !== v[0]) begin
                n_fail++;
                $display("FAIL ccc_%b_flags_%b: pc=%h taken=%b, expected pc=%h taken=%b",
                         v[6:4], v[3:1], bus.pc, bus.taken, exp_pc, v[0]);
            end
        end
        // Both branch strobes: BR target wins over B offset.
        jump_to(16'h0300);
        bus.br_en   = 1'b1;
        bus.br_reg  = 1'b1;
        bus.ccc     = 3'b111;
        bus.imm9    = 9'h001;
        bus.reg_tgt = 16'h4444;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h4444) begin
            n_fail++;
            $display("FAIL both_branch: pc=%h, expected 4444", bus.pc);
        end
    endtask

    task automatic test_wrap();
        jump_to(16'hFFFE);
        tick();
        n_tests++;
        if (bus.pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL seq_wrap: pc=%h, expected 0000", bus.pc);
        end
        jump_to(16'hFFFC);
        bus.br_en = 1'b1;
        bus.ccc   = 3'b111;
        bus.imm9  = 9'h001;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.taken !== 1'b1) begin
            n_fail++;
            $display("FAIL b_wrap: pc=%h taken=%b, expected pc=0000 taken=1", bus.pc, bus.taken);
        end
    endtask

    task automatic test_stall();
        // Stall right after a taken jump must also clear taken.
        jump_to(16'h0040);
        bus.stall   = 1'b1;
        bus.br_reg  = 1'b1;
        bus.ccc     = 3'b111;
        bus.reg_tgt = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.pc !== 16'h0040 || bus.taken !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: pc=%h taken=%b, expected pc=0040 taken=0",
                         i, bus.pc, bus.taken);
            end
        end
        bus.stall = 1'b0;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h1234 || bus.taken !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h taken=%b, expected pc=1234 taken=1", bus.pc, bus.taken);
        end
        // hlt under stall is ignored.
        bus.stall = 1'b1;
        bus.hlt   = 1'b1;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.halted !== 1'b0 || bus.pc !== 16'h1234) begin
            n_fail++;
            $display("FAIL stall_over_hlt: pc=%h halted=%b, expected pc=1234 halted=0", bus.pc, bus.halted);
        end
    endtask

    task automatic test_halt();
        int bad;
        jump_to(16'h0020);
        // hlt outranks a concurrent taken branch.
        bus.hlt     = 1'b1;
        bus.br_reg  = 1'b1;
        bus.ccc     = 3'b111;
        bus.reg_tgt = 16'h0099;
        tick();
        n_tests++;
        if (bus.pc !== 16'h0020 || bus.halted !== 1'b1 || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter: pc=%h halted=%b taken=%b, expected pc=0020 halted=1 taken=0",
                     bus.pc, bus.halted, bus.taken);
        end
        bus.hlt   = 1'b0;
        bus.br_en = 1'b1;
        bus.imm9  = 9'h005;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.pc !== 16'h0020 || bus.halted !== 1'b1 || bus.taken !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_hold: %0d of 10 cycles left pc=0020/halted=1/taken=0 (last pc=%h halted=%b)",
                     bad, bus.pc, bus.halted);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.halted !== 1'b0 || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: pc=%h halted=%b taken=%b, expected pc=0000 halted=0 taken=0",
                     bus.pc, bus.halted, bus.taken);
        end
        tick();
        n_tests++;
        if (bus.pc !== 16'h0002) begin
            n_fail++;
            $display("FAIL post_reset_run: pc=%h, expected 0002", bus.pc);
        end
    endtask

`ifdef PC_BR_CNT_EN
    task automatic test_br_cnt();
        logic [3:0] outcome;   // 1 = taken (flags Z=1), 0 = not taken
        outcome = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.br_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL br_cnt_reset: br_cnt=%h, expected 0000", bus.br_cnt);
        end
        // Pattern T, N, T, N, T.
        for (int i = 0; i < 5; i++) begin
            bus.br_en = 1'b1;
            bus.ccc   = 3'b001;
            bus.flags = (i % 2 == 0) ? 3'b001 : 3'b000;
            bus.imm9  = 9'h000;
            tick();
        end
        idle_inputs();
        tick();
        n_tests++;
        if (bus.br_cnt !== 16'h0003) begin
            n_fail++;
            $display("FAIL br_cnt_count: br_cnt=%h, expected 0003", bus.br_cnt);
        end
        force dut.br_cnt_q = 16'hFFFE;
        #1;
        release dut.br_cnt_q;
        for (int i = 0; i < 3; i++) begin
            bus.br_reg  = 1'b1;
            bus.ccc     = 3'b111;
            bus.reg_tgt = 16'h0500;
            tick();
        end
        idle_inputs();
        n_tests++;
        if (bus.br_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL br_cnt_sat: br_cnt=%h, expected ffff", bus.br_cnt);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();
        test_reset();
        test_b_branch();
        test_cond_codes();
        test_wrap();
        test_stall();
        test_halt();
`ifdef PC_BR_CNT_EN
        test_br_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
